// File: rtl/ram_rdstream_pkg.sv
// Shared types and helpers for the RAM read streamer.
// Imported by ram_rdstream and ram_rdstream_buf.
package ram_rdstream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  localparam int BUF_DEPTH = 2;

  // addr < count and inc < 2*count, so two conditional subtractions cover
  // every case without a divider, including non-power-of-2 depths.
  function automatic int unsigned addr_next(input int unsigned addr,
                                            input int unsigned inc,
                                            input int unsigned count);
    int unsigned sum;
    sum = addr + inc;
    if (sum >= count) sum = sum - count;
    if (sum >= count) sum = sum - count;
    return sum;
  endfunction

endpackage

// File: rtl/ram_rdstream_if.sv
// Output beat stream of the RAM read streamer.
// A beat transfers on a rising edge where valid & ready are both high; once
// valid is raised it stays high, with data and last held, until that edge.
interface ram_rdstream_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [WORD_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/ram_rdstream_buf.sv
// Two-entry {data, last} FIFO between the RAM read port and the beat stream.
// Push and pop in the same cycle are both honoured.
module ram_rdstream_buf
  import ram_rdstream_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WORD_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [1:0]            count_o
);

  logic [WORD_WIDTH-1:0] data_q [BUF_DEPTH];
  logic                  last_q [BUF_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  pop;

  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o & ready_i;
  assign data_o  = data_q[rd_ptr_q];
  assign last_o  = valid_o & last_q[rd_ptr_q];
  assign count_o = count_q;
  assign count_d = count_q + {1'b0, push_i} - {1'b0, pop};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
    end else begin
      if (push_i) begin
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: it is only observed while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push_i) data_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ram_rdstream.sv
// Streams a burst of consecutive RAM words as valid/ready beats with a last flag.
// Optional RAM_RDSTREAM_STRIDE_EN adds cmd_stride_i (address step, default 1).
module ram_rdstream
  import ram_rdstream_pkg::*;
#(
  parameter  int WORD_WIDTH = 32,
  parameter  int WORD_COUNT = 256,
  localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
  localparam int LEN_WIDTH  = $clog2(WORD_COUNT + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
`ifdef RAM_RDSTREAM_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride_i,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [WORD_WIDTH-1:0] ram_data_i,
  ram_rdstream_if.master        m,
  output logic                  busy_o,
  output logic                  done_o,
  output state_e                state_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [ADDR_WIDTH-1:0] stride;
  logic                  cmd_hs;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;
  logic [1:0]            buf_count;
  logic                  buf_valid;
  logic                  buf_last;
  logic [WORD_WIDTH-1:0] buf_data;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign state_o     = state_q;
  assign cmd_hs      = cmd_valid_i & cmd_ready_o;

  assign m.valid = buf_valid;
  assign m.data  = buf_data;
  assign m.last  = buf_last;
  assign pop     = buf_valid & m.ready;

`ifdef RAM_RDSTREAM_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)       stride_q <= '0;
    else if (cmd_hs) stride_q <= cmd_stride_i;
  end
  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  // Issue only while the word it produces is guaranteed a buffer slot.
  assign occ   = {1'b0, buf_count} + {2'b0, inflight_q};
  assign issue = (state_q == READ) && (occ <= (3'd1 + {2'b0, pop}));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    ram_addr_o      = ram_addr_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d  = cmd_addr_i;
          rem_d   = cmd_len_i;
          state_d = (cmd_len_i == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          ram_addr_o      = addr_q;
          addr_d          = ADDR_WIDTH'(addr_next(32'(addr_q), 32'(stride), 32'(WORD_COUNT)));
          rem_d           = rem_q - LEN_WIDTH'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (rem_q == LEN_WIDTH'(1));
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && buf_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      ram_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      ram_addr_q      <= ram_addr_o;
    end
  end

  ram_rdstream_buf #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (inflight_q),
    .push_data_i(ram_data_i),
    .push_last_i(inflight_last_q),
    .valid_o    (buf_valid),
    .ready_i    (m.ready),
    .data_o     (buf_data),
    .last_o     (buf_last),
    .count_o    (buf_count)
  );

  a_len_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (cmd_valid_i && cmd_ready_o) |-> (cmd_len_i <= LEN_WIDTH'(WORD_COUNT)));

endmodule
